// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the parametrised load/store unit.
//   state_t    : access FSM states
//   size_t     : access size encoding (1, 2 or 4 bytes)
//   size_bytes : byte count of an access size
//   byte_mask  : byte-enable pattern of n bytes starting at lane, spanning two bus words
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic [2:0] size_bytes(input size_t size);
    return 3'd1 << size;
  endfunction

  // Low half of the result enables beat 0, high half (above BUS_BYTES) beat 1.
  function automatic logic [7:0] byte_mask(input logic [1:0] lane, input logic [2:0] n);
    logic [7:0] low;
    low = (8'd1 << n) - 8'd1;
    return low << lane;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Interfaces of the load/store unit.
//   mem_req_if : core side. master = execution core, slave = mem_access_unit.
//     req_valid/req_ready handshake, req_segment/offset/io/wr/size/wdata,
//     rsp_valid pulse with rsp_rdata/rsp_error, busy.
//   mem_bus_if : memory/IO bus side. master = mem_access_unit, slave = memory.
//     m_addr (bus-word address), m_data_out/m_data_in, m_access/m_ack beat
//     handshake, m_wr_en, m_bytesel lane enables.
interface mem_req_if #(parameter int BUS_BYTES = 2);
  logic                   req_valid;
  logic                   req_ready;
  logic [15:0]            req_segment;
  logic [15:0]            req_offset;
  logic                   req_io;
  logic                   req_wr;
  logic [1:0]             req_size;
  logic [8*BUS_BYTES-1:0] req_wdata;
  logic                   rsp_valid;
  logic [8*BUS_BYTES-1:0] rsp_rdata;
  logic                   rsp_error;
  logic                   busy;

  modport master (
    output req_valid, req_segment, req_offset, req_io, req_wr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
  modport slave (
    input  req_valid, req_segment, req_offset, req_io, req_wr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
endinterface

interface mem_bus_if #(parameter int BUS_BYTES = 2, parameter int PHYS_ADDR_W = 20);
  logic [PHYS_ADDR_W-$clog2(BUS_BYTES)-1:0] m_addr;
  logic [8*BUS_BYTES-1:0]                   m_data_in;
  logic [8*BUS_BYTES-1:0]                   m_data_out;
  logic                                     m_access;
  logic                                     m_ack;
  logic                                     m_wr_en;
  logic [BUS_BYTES-1:0]                     m_bytesel;

  modport master (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    input  m_data_in, m_ack
  );
  modport slave (
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    output m_data_in, m_ack
  );
endinterface

// File: rtl/mem_access_beat_gen.sv
// Combinational lane steering for one access.
//   i_active   : a beat is on the bus (outputs are zero otherwise)
//   i_second   : current beat is beat 1 of a split access
//   i_lane     : byte lane of the start address
//   i_size     : access size
//   i_wdata    : LSB-justified store data
//   i_rd_lo/hi : bus words holding the low / high part of the load
//   o_bytesel  : lane enables for the current beat
//   o_data_out : store data shifted into the current beat's lanes
//   o_rdata    : load data, LSB-justified, zero above the access size
module mem_access_beat_gen
  import mem_access_pkg::*;
#(
  parameter int BUS_BYTES = 2
) (
  input  logic                          i_active,
  input  logic                          i_second,
  input  logic [$clog2(BUS_BYTES)-1:0]  i_lane,
  input  size_t                         i_size,
  input  logic [8*BUS_BYTES-1:0]        i_wdata,
  input  logic [8*BUS_BYTES-1:0]        i_rd_lo,
  input  logic [8*BUS_BYTES-1:0]        i_rd_hi,
  output logic [BUS_BYTES-1:0]          o_bytesel,
  output logic [8*BUS_BYTES-1:0]        o_data_out,
  output logic [8*BUS_BYTES-1:0]        o_rdata
);

  localparam int DW = 8 * BUS_BYTES;
  localparam int SW = 2 * BUS_BYTES;

  logic [2:0]      w_n;
  logic [SW-1:0]   w_sel_pair;
  logic [2*DW-1:0] w_wr_pair;
  logic [DW-1:0]   w_keep;

  // Shifting across a double-width word yields both beats at once:
  // the low word is beat 0, the high word is beat 1.
  assign w_n        = size_bytes(i_size);
  assign w_sel_pair = SW'(byte_mask(2'(i_lane), w_n));
  assign w_wr_pair  = {{DW{1'b0}}, i_wdata} << {i_lane, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_bytesel  = '0;
    o_data_out = '0;
    if (i_active) begin
      o_bytesel  = i_second ? w_sel_pair[SW-1:BUS_BYTES] : w_sel_pair[BUS_BYTES-1:0];
      o_data_out = i_second ? w_wr_pair[2*DW-1:DW]       : w_wr_pair[DW-1:0];
    end
  end

  always_comb begin
    w_keep = '0;
    for (int b = 0; b < BUS_BYTES; b++) begin
      w_keep[8*b +: 8] = (b < int'(w_n)) ? 8'hFF : 8'h00;
    end
  end

  assign o_rdata = DW'({i_rd_hi, i_rd_lo} >> {i_lane, 3'b000}) & w_keep;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execution core and the memory/IO bus.
// Forms the segment:offset or IO address, splits accesses that cross a
// bus-word boundary into two beats, and aborts a hung beat after TIMEOUT
// cycles (0 = never).
//   clk, reset : clock, asynchronous active-high reset
//   req        : core-side request/response (mem_req_if.slave)
//   bus        : memory/IO bus beats (mem_bus_if.master)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int BUS_BYTES   = 2,
  parameter int PHYS_ADDR_W = 20,
  parameter int TIMEOUT     = 0
) (
  input  logic      clk,
  input  logic      reset,
  mem_req_if.slave  req,
  mem_bus_if.master bus
);

  localparam int LB = $clog2(BUS_BYTES);
  localparam int DW = 8 * BUS_BYTES;
  localparam int WW = PHYS_ADDR_W - LB;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                 r_state, w_next;
  logic [PHYS_ADDR_W-1:0] r_addr, w_lin;
  logic                   r_wr, r_split, r_rsp_error;
  size_t                  r_size;
  logic [DW-1:0]          r_wdata, r_lo, r_rsp_rdata;
  logic [TW-1:0]          r_tcnt;

  logic                   w_accept, w_split, w_active, w_timeout, w_done;
  logic [WW-1:0]          w_word;
  logic [DW-1:0]          w_rd_lo, w_rd_hi, w_merge;

  // Memory space wraps modulo 2^PHYS_ADDR_W; IO space is the bare offset.
  assign w_lin = req.req_io ? PHYS_ADDR_W'(req.req_offset)
                            : PHYS_ADDR_W'(24'({req.req_segment, 4'b0000}) + 24'(req.req_offset));

  assign w_accept  = (r_state == IDLE) && req.req_valid;
  assign w_split   = (int'(w_lin[LB-1:0]) + int'(size_bytes(size_t'(req.req_size)))) > BUS_BYTES;
  assign w_active  = (r_state == BEAT0) || (r_state == BEAT1);
  assign w_done    = w_active && bus.m_ack && ((r_state == BEAT1) || !r_split);
  assign w_timeout = (TIMEOUT > 0) && w_active && !bus.m_ack && (int'(r_tcnt) == TIMEOUT - 1);
  assign w_word    = r_addr[PHYS_ADDR_W-1:LB];

  // Beat 1 merges the captured beat-0 word (low) with the live bus word (high).
  assign w_rd_lo = (r_state == BEAT1) ? r_lo : bus.m_data_in;
  assign w_rd_hi = (r_state == BEAT1) ? bus.m_data_in : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req.req_valid) w_next = BEAT0;
      BEAT0:   if (bus.m_ack)     w_next = r_split ? BEAT1 : RESP;
               else if (w_timeout) w_next = RESP;
      BEAT1:   if (bus.m_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs, decoded from registered state and the captured request only
  always_comb begin
    req.req_ready = (r_state == IDLE);
    req.busy      = (r_state != IDLE);
    req.rsp_valid = (r_state == RESP);
    req.rsp_rdata = r_rsp_rdata;
    req.rsp_error = r_rsp_error;
    bus.m_access  = w_active;
    bus.m_wr_en   = w_active && r_wr;
    bus.m_addr    = '0;
    if (w_active) bus.m_addr = (r_state == BEAT1) ? w_word + WW'(1) : w_word;
  end

  // Captured request, per-beat timer and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_wdata     <= '0;
      r_split     <= 1'b0;
      r_lo        <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_tcnt      <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_lin;
        r_wr    <= req.req_wr;
        r_size  <= size_t'(req.req_size);
        r_wdata <= req.req_wdata;
        r_split <= w_split;
      end
      // Every beat entry is a state change, so this clears the timer per beat.
      if (w_next != r_state) r_tcnt <= '0;
      else if (w_active)     r_tcnt <= r_tcnt + TW'(1);
      if ((r_state == BEAT0) && bus.m_ack) r_lo <= bus.m_data_in;
      if (w_done) begin
        r_rsp_rdata <= r_wr ? '0 : w_merge;
        r_rsp_error <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_error <= 1'b1;
      end
    end
  end

  mem_access_beat_gen #(.BUS_BYTES(BUS_BYTES)) u_beat_gen (
    .i_active   (w_active),
    .i_second   (r_state == BEAT1),
    .i_lane     (r_addr[LB-1:0]),
    .i_size     (r_size),
    .i_wdata    (r_wdata),
    .i_rd_lo    (w_rd_lo),
    .i_rd_hi    (w_rd_hi),
    .o_bytesel  (bus.m_bytesel),
    .o_data_out (bus.m_data_out),
    .o_rdata    (w_merge)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 2-byte bus instance with an 8-cycle
// timeout and a 4-byte bus instance without timeout, sharing clock and reset.
module tb_mem_access_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_req_if #(.BUS_BYTES(2))                    rq2 ();
  mem_bus_if #(.BUS_BYTES(2), .PHYS_ADDR_W(20))  bs2 ();
  mem_req_if #(.BUS_BYTES(4))                    rq4 ();
  mem_bus_if #(.BUS_BYTES(4), .PHYS_ADDR_W(20))  bs4 ();

  mem_access_unit #(.BUS_BYTES(2), .PHYS_ADDR_W(20), .TIMEOUT(8)) u2 (
    .clk(clk), .reset(reset), .req(rq2), .bus(bs2));
  mem_access_unit #(.BUS_BYTES(4), .PHYS_ADDR_W(20), .TIMEOUT(0)) u4 (
    .clk(clk), .reset(reset), .req(rq4), .bus(bs4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [15:0] seg, input logic [15:0] off, input logic io,
                       input logic wr, input logic [1:0] sz, input logic [15:0] wd);
    rq2.req_segment = seg; rq2.req_offset = off; rq2.req_io = io;
    rq2.req_wr = wr; rq2.req_size = sz; rq2.req_wdata = wd;
    rq2.req_valid = 1'b1;
    step();
    rq2.req_valid = 1'b0;
  endtask

  task automatic send4(input logic [15:0] seg, input logic [15:0] off, input logic io,
                       input logic wr, input logic [1:0] sz, input logic [31:0] wd);
    rq4.req_segment = seg; rq4.req_offset = off; rq4.req_io = io;
    rq4.req_wr = wr; rq4.req_size = sz; rq4.req_wdata = wd;
    rq4.req_valid = 1'b1;
    step();
    rq4.req_valid = 1'b0;
  endtask

  initial begin
    rq2.req_valid = 0; rq2.req_segment = 0; rq2.req_offset = 0; rq2.req_io = 0;
    rq2.req_wr = 0; rq2.req_size = 0; rq2.req_wdata = 0;
    rq4.req_valid = 0; rq4.req_segment = 0; rq4.req_offset = 0; rq4.req_io = 0;
    rq4.req_wr = 0; rq4.req_size = 0; rq4.req_wdata = 0;
    bs2.m_ack = 0; bs2.m_data_in = 0;
    bs4.m_ack = 0; bs4.m_data_in = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready2",   rq2.req_ready,  1);
    chk("rst_busy2",    rq2.busy,       0);
    chk("rst_rsp2",     rq2.rsp_valid,  0);
    chk("rst_rdata2",   rq2.rsp_rdata,  0);
    chk("rst_err2",     rq2.rsp_error,  0);
    chk("rst_access2",  bs2.m_access,   0);
    chk("rst_addr2",    bs2.m_addr,     0);
    chk("rst_sel2",     bs2.m_bytesel,  0);
    chk("rst_dout2",    bs2.m_data_out, 0);
    chk("rst_wren2",    bs2.m_wr_en,    0);
    chk("rst_ready4",   rq4.req_ready,  1);
    chk("rst_access4",  bs4.m_access,   0);
    reset = 1'b0;

    // m_ack is ignored while idle
    bs2.m_ack = 1;
    step();
    chk("idle_ack_ready",  rq2.req_ready, 1);
    chk("idle_ack_access", bs2.m_access,  0);
    bs2.m_ack = 0;

    // Split word load, A = 0x10003 (lane 1)
    send2(16'h1000, 16'h0003, 0, 0, 2'd1, 16'h0);
    chk("wl_b0_access", bs2.m_access,  1);
    chk("wl_b0_addr",   bs2.m_addr,    32'h8001);
    chk("wl_b0_sel",    bs2.m_bytesel, 32'b10);
    chk("wl_b0_wren",   bs2.m_wr_en,   0);
    chk("wl_b0_busy",   rq2.busy,      1);
    chk("wl_b0_ready",  rq2.req_ready, 0);
    bs2.m_data_in = 16'hAA11; bs2.m_ack = 1;
    step();
    chk("wl_b1_addr",   bs2.m_addr,    32'h8002);
    chk("wl_b1_sel",    bs2.m_bytesel, 32'b01);
    chk("wl_b1_rsp",    rq2.rsp_valid, 0);
    bs2.m_data_in = 16'h22BB;
    step();
    bs2.m_ack = 0;
    chk("wl_rsp_valid", rq2.rsp_valid, 1);
    chk("wl_rsp_access", bs2.m_access, 0);
    // Byte 0x10003 is the upper lane of 0xAA11 (0xAA); byte 0x10004 is the low lane of 0x22BB (0xBB)
    chk("wl_rdata",     rq2.rsp_rdata, 32'hBBAA);
    chk("wl_err",       rq2.rsp_error, 0);
    step();
    chk("wl_idle_rsp",  rq2.rsp_valid, 0);
    chk("wl_idle_ready", rq2.req_ready, 1);
    chk("wl_hold_rdata", rq2.rsp_rdata, 32'hBBAA);

    // IO byte load, port 0x0061; the segment must not contribute
    send2(16'h1234, 16'h0061, 1, 0, 2'd0, 16'h0);
    chk("io_addr", bs2.m_addr,    32'h30);
    chk("io_sel",  bs2.m_bytesel, 32'b10);
    bs2.m_data_in = 16'h5A00; bs2.m_ack = 1;
    step();
    bs2.m_ack = 0;
    chk("io_rsp",   rq2.rsp_valid, 1);
    chk("io_rdata", rq2.rsp_rdata, 32'h005A);
    step();

    // Address wrap: 0xFFFF0 + 0x10 = 0x00000, aligned single beat
    send2(16'hFFFF, 16'h0010, 0, 0, 2'd1, 16'h0);
    chk("wrap0_addr", bs2.m_addr,    32'h0);
    chk("wrap0_sel",  bs2.m_bytesel, 32'b11);
    bs2.m_data_in = 16'h1357; bs2.m_ack = 1;
    step();
    bs2.m_ack = 0;
    chk("wrap0_rsp",   rq2.rsp_valid, 1);
    chk("wrap0_rdata", rq2.rsp_rdata, 32'h1357);
    step();

    // A = 0xFFFFF: split, beat 1 word address wraps to 0
    send2(16'hFFFF, 16'h000F, 0, 0, 2'd1, 16'h0);
    chk("wrapf_b0_addr", bs2.m_addr,    32'h7FFFF);
    chk("wrapf_b0_sel",  bs2.m_bytesel, 32'b10);
    bs2.m_data_in = 16'hCC00; bs2.m_ack = 1;
    step();
    chk("wrapf_b1_addr", bs2.m_addr,    32'h0);
    chk("wrapf_b1_sel",  bs2.m_bytesel, 32'b01);
    bs2.m_data_in = 16'h00DD;
    step();
    bs2.m_ack = 0;
    chk("wrapf_rsp",   rq2.rsp_valid, 1);
    chk("wrapf_rdata", rq2.rsp_rdata, 32'hDDCC);
    step();

    // Timeout: no m_ack, beat held for exactly 8 cycles
    bs2.m_data_in = 16'h7777;
    send2(16'h0000, 16'h0020, 0, 0, 2'd1, 16'h0);
    chk("to_access_0", bs2.m_access, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("to_access_%0d", i), bs2.m_access, 1);
    end
    step();
    chk("to_access_drop", bs2.m_access,  0);
    chk("to_rsp",         rq2.rsp_valid, 1);
    chk("to_err",         rq2.rsp_error, 1);
    chk("to_rdata",       rq2.rsp_rdata, 0);
    step();

    // Next request proceeds normally after the abort
    send2(16'h0000, 16'h0040, 0, 0, 2'd1, 16'h0);
    chk("post_addr", bs2.m_addr, 32'h20);
    bs2.m_data_in = 16'h4321; bs2.m_ack = 1;
    step();
    bs2.m_ack = 0;
    chk("post_rsp",   rq2.rsp_valid, 1);
    chk("post_err",   rq2.rsp_error, 0);
    chk("post_rdata", rq2.rsp_rdata, 32'h4321);
    step();

    // 4-byte bus: split 2-byte store at A = 7 (lane 3)
    send4(16'h0000, 16'h0007, 0, 1, 2'd1, 32'h1234);
    chk("st4_b0_addr", bs4.m_addr,     32'h1);
    chk("st4_b0_sel",  bs4.m_bytesel,  32'b1000);
    chk("st4_b0_data", bs4.m_data_out, 32'h34000000);
    chk("st4_b0_wren", bs4.m_wr_en,    1);
    bs4.m_ack = 1;
    step();
    chk("st4_b1_addr", bs4.m_addr,     32'h2);
    chk("st4_b1_sel",  bs4.m_bytesel,  32'b0001);
    chk("st4_b1_data", bs4.m_data_out, 32'h00000012);
    step();
    bs4.m_ack = 0;
    chk("st4_rsp",      rq4.rsp_valid,  1);
    chk("st4_err",      rq4.rsp_error,  0);
    chk("st4_idle_sel", bs4.m_bytesel,  0);
    chk("st4_idle_dat", bs4.m_data_out, 0);
    step();

    // Aligned 4-byte load: rsp_valid in cycle 2 after acceptance
    send4(16'h0000, 16'h0008, 0, 0, 2'd2, 32'h0);
    chk("ld4_addr", bs4.m_addr,    32'h2);
    chk("ld4_sel",  bs4.m_bytesel, 32'b1111);
    chk("ld4_c1_rsp", rq4.rsp_valid, 0);
    bs4.m_data_in = 32'hDEADBEEF; bs4.m_ack = 1;
    step();
    bs4.m_ack = 0;
    chk("ld4_c2_rsp", rq4.rsp_valid, 1);
    chk("ld4_rdata",  rq4.rsp_rdata, 32'hDEADBEEF);
    step();

    // Byte load at lane 2, zero-extended
    send4(16'h0000, 16'h0006, 0, 0, 2'd0, 32'h0);
    chk("lb4_addr", bs4.m_addr,    32'h1);
    chk("lb4_sel",  bs4.m_bytesel, 32'b0100);
    bs4.m_data_in = 32'h11223344; bs4.m_ack = 1;
    step();
    bs4.m_ack = 0;
    chk("lb4_rdata", rq4.rsp_rdata, 32'h00000022);
    step();

    // Reset during beat 1 of a split store
    send2(16'h0000, 16'h0005, 0, 1, 2'd1, 16'hBEEF);
    chk("rs_b0_sel",  bs2.m_bytesel,  32'b10);
    chk("rs_b0_data", bs2.m_data_out, 32'hEF00);
    bs2.m_ack = 1;
    step();
    bs2.m_ack = 0;
    chk("rs_b1_addr", bs2.m_addr,     32'h3);
    chk("rs_b1_data", bs2.m_data_out, 32'h00BE);
    chk("rs_b1_wren", bs2.m_wr_en,    1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async_access", bs2.m_access,  0);
    chk("rs_async_ready",  rq2.req_ready, 1);
    chk("rs_async_rsp",    rq2.rsp_valid, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rs_no_rsp_%0d", i), rq2.rsp_valid, 0);
    end
    chk("rs_ready_after", rq2.req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
